rnd_hex_display: RTL and testbench

Downstream consumer of the 16-bit pseudo-random generator in the random-hex demo. Periodically (or on a capture request) samples the generator's 16-bit word into a hold register, and drives a 4-digit, time-multiplexed, common-anode 7-segment display with that value as four hex digits. Outputs go straight to board pins.

---
 rtl/rnd_hex_display.sv | 119 +++++++++++
 tb/tb_rnd_hex_display.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rnd_hex_display.sv
// rnd_hex_display
//   Samples a 16-bit pseudo-random word into a hold register. A sample is
//   taken every SAMPLE_DIV cycles unless i_freeze is high, and on every
//   rising edge of i_capture. The held value is shown as four hex digits on
//   a time-multiplexed, common-anode 7-segment display.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_data       random word from the generator (sampled only)
//   i_capture    synchronous request; each 0->1 edge forces one sample
//   i_freeze     level; suppresses automatic samples while high
//   o_seg        segments, active-low, bit0=a .. bit6=g
//   o_dig        digit enables, active-low, bit0 = rightmost digit
//   o_value      currently held value
//   o_sample_stb one-cycle pulse in the cycle after the hold register loads
module rnd_hex_display #(
    parameter int SCAN_DIV   = 50000,
    parameter int SAMPLE_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_data,
    input  logic        i_capture,
    input  logic        i_freeze,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_dig,
    output logic [15:0] o_value,
    output logic        o_sample_stb
);

    localparam int SW = $clog2(SAMPLE_DIV);
    // SCAN_DIV may be 1, so keep the scan counter at least one bit wide.
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SMAX = SW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);

    logic [15:0]   value_q, value_d;
    logic [SW-1:0] scnt_q,  scnt_d;
    logic          cap_q,   cap_d;
    logic          stb_q,   stb_d;
    logic [DW-1:0] dcnt_q,  dcnt_d;
    logic [1:0]    idx_q,   idx_d;
    logic [6:0]    seg_q,   seg_d;
    logic [3:0]    dig_q,   dig_d;

    logic rise, swrap, dwrap, load;

    // Active-high gfedcba encoding of one hex digit.
    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h3F;
            4'h1: enc = 7'h06;
            4'h2: enc = 7'h5B;
            4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66;
            4'h5: enc = 7'h6D;
            4'h6: enc = 7'h7D;
            4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F;
            4'h9: enc = 7'h6F;
            4'hA: enc = 7'h77;
            4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39;
            4'hD: enc = 7'h5E;
            4'hE: enc = 7'h79;
            default: enc = 7'h71;
        endcase
    endfunction

    always_comb begin
        rise  = i_capture & ~cap_q;
        swrap = (scnt_q == SMAX);
        // A capture coinciding with the wrap still produces a single load.
        load  = rise | (swrap & ~i_freeze);

        value_d = load ? i_data : value_q;
        // The counter keeps running under freeze; a capture restarts it.
        scnt_d  = (rise | swrap) ? '0 : scnt_q + 1'b1;
        cap_d   = i_capture;
        stb_d   = load;

        dwrap  = (dcnt_q == DMAX);
        dcnt_d = dwrap ? '0 : dcnt_q + 1'b1;
        idx_d  = dwrap ? idx_q + 2'd1 : idx_q;

        // Display register follows the current idx/value, one cycle behind.
        dig_d = ~(4'b0001 << idx_q);
        seg_d = ~enc(value_q[{idx_q, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            scnt_q  <= '0;
            cap_q   <= 1'b0;
            stb_q   <= 1'b0;
            dcnt_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= 4'hF;
        end else begin
            value_q <= value_d;
            scnt_q  <= scnt_d;
            cap_q   <= cap_d;
            stb_q   <= stb_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_dig        = dig_q;
    assign o_value      = value_q;
    assign o_sample_stb = stb_q;

endmodule

// File: tb/tb_rnd_hex_display.sv
module tb_rnd_hex_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_capture;
    logic        i_freeze;
    logic [6:0]  o_seg;
    logic [3:0]  o_dig;
    logic [15:0] o_value;
    logic        o_sample_stb;

    rnd_hex_display #(.SCAN_DIV(4), .SAMPLE_DIV(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_capture(i_capture),
        .i_freeze(i_freeze), .o_seg(o_seg), .o_dig(o_dig), .o_value(o_value),
        .o_sample_stb(o_sample_stb)
    );

    always #5 clk = ~clk;

    // Edge number since the last reset release (edge 1 = first posedge).
    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    typedef struct {
        logic [15:0] v;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] dig_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // 1A3F right->left: F, 3, A, 1
    logic [6:0] seg_tab [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Monitor: every strobe must match the next expected load (value and edge).
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && o_sample_stb === 1'b1) begin
            if (sb.size() == 0) begin
                chk("stb_unexpected", {31'd0, o_sample_stb}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("stb_value", {16'd0, o_value}, {16'd0, mon_e.v});
                chk("stb_edge", cyc, mon_e.at);
            end
        end
    end

    initial begin
        int d;
        rst_n = 1'b0; i_data = 16'h1A3F; i_capture = 1'b0; i_freeze = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dig",   {28'd0, o_dig},   32'hF);
        chk("rst_seg",   {25'd0, o_seg},   32'h7F);
        chk("rst_value", {16'd0, o_value}, 32'h0);
        chk("rst_stb",   {31'd0, o_sample_stb}, 32'h0);

        sb.push_back('{16'h1A3F, 16});
        sb.push_back('{16'h1A3F, 32});
        rst_n = 1'b1;

        // Scan sequence: blank value for 16 edges, then 1A3F digits.
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            chk("scan_dig", {28'd0, o_dig}, {28'd0, dig_tab[d]});
            chk("scan_seg", {25'd0, o_seg}, (k <= 16) ? 32'h40 : {25'd0, seg_tab[d]});
        end

        // Freeze for 64 cycles with changing data.
        i_freeze = 1'b1;
        for (int k = 0; k < 64; k++) begin
            i_data = 16'(k * 37 + 5);
            @(negedge clk);
        end
        chk("freeze_hold", {16'd0, o_value}, 32'h1A3F);
        i_freeze = 1'b0;
        i_data   = 16'h5A5A;
        sb.push_back('{16'h5A5A, 112});
        goto(111);
        chk("unfreeze_wait", {16'd0, o_value}, 32'h1A3F);
        goto(112);
        chk("unfreeze_load", {16'd0, o_value}, 32'h5A5A);

        // Capture pulse with scnt==5.
        goto(117);
        i_data = 16'hBEEF; i_capture = 1'b1;
        sb.push_back('{16'hBEEF, 118});
        @(negedge clk);
        chk("cap_immediate", {16'd0, o_value}, 32'hBEEF);
        i_capture = 1'b0; i_data = 16'h1234;
        sb.push_back('{16'h1234, 134});
        goto(133);
        chk("cap_restart", {16'd0, o_value}, 32'hBEEF);
        goto(134);

        // Capture held high for 40 cycles under freeze: one load only.
        i_capture = 1'b1; i_freeze = 1'b1; i_data = 16'hC0DE;
        sb.push_back('{16'hC0DE, 135});
        goto(140);
        i_data = 16'hDEAD;
        goto(174);
        chk("hold_one_cap", {16'd0, o_value}, 32'hC0DE);
        i_capture = 1'b0; i_freeze = 1'b0; i_data = 16'h7777;

        // Capture rise coinciding with scnt==15.
        goto(182);
        i_capture = 1'b1;
        sb.push_back('{16'h7777, 183});
        @(negedge clk);
        i_capture = 1'b0; i_data = 16'h0F0F;
        sb.push_back('{16'h0F0F, 199});

        // Load BEEF, then reset while idx==2.
        goto(199);
        i_data = 16'hBEEF; i_capture = 1'b1;
        sb.push_back('{16'hBEEF, 200});
        @(negedge clk);
        i_capture = 1'b0;
        goto(202);
        chk("pre_rst_value", {16'd0, o_value}, 32'hBEEF);
        chk("pre_rst_dig",   {28'd0, o_dig},   32'hB);
        chk("pre_rst_seg",   {25'd0, o_seg},   32'h06);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dig",   {28'd0, o_dig},   32'hF);
        chk("async_rst_seg",   {25'd0, o_seg},   32'h7F);
        chk("async_rst_value", {16'd0, o_value}, 32'h0);
        chk("async_rst_stb",   {31'd0, o_sample_stb}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            chk("post_rst_dig", {28'd0, o_dig}, {28'd0, dig_tab[d]});
            chk("post_rst_seg", {25'd0, o_seg}, 32'h40);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
